store_unit: RTL and testbench

// Write-side counterpart to the register file's load-byte extraction. Takes
// sb/sh/sw requests from the datapath (opcode, byte address, rt data) and

---
 rtl/store_unit.sv | 167 ++++++++++++++++
 tb/tb_store_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Store unit: aligns sb/sh/sw data to byte lanes, drives a word-wide data memory,
// and flags misaligned/illegal stores. Define STORE_RMW_EN for memories without byte enables.
module store_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [5:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_done,
  output logic             st_err,
  output logic [CNT_W-1:0] st_count,
  output logic             mem_req,
  output logic             mem_we,
  output logic [29:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata
);

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_WAIT_R = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [29:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             err_q;
  logic [CNT_W-1:0] count_q;

  logic [1:0]       lane;
  logic [31:0]      req_wdata;
  logic [3:0]       req_be;
  logic             req_err;
  logic             req_rmw;
  logic             accept;

  assign lane   = st_addr[1:0];
  assign accept = st_valid && st_ready;

  // Decode the incoming request into lane-replicated data, byte enables and an error flag
  always_comb begin
    req_wdata = 32'h0;
    req_be    = 4'h0;
    req_err   = 1'b0;
    case (st_op)
      OP_SB: begin
        req_wdata = {4{st_data[7:0]}};
        req_be    = 4'b0001 << lane;
      end
      OP_SH: begin
        req_wdata = {2{st_data[15:0]}};
        req_be    = 4'b0011 << lane;
        req_err   = lane[0];
      end
      OP_SW: begin
        req_wdata = st_data;
        req_be    = 4'b1111;
        req_err   = (lane != 2'b00);
      end
      default: req_err = 1'b1;
    endcase
  end

`ifdef STORE_RMW_EN
  logic [31:0] lane_mask;
  logic [31:0] merged;

  // Partial stores must read the old word first since the memory ignores mem_be
  assign req_rmw   = !req_err && (req_be != 4'b1111);
  assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign merged    = (wdata_q & lane_mask) | (mem_rdata & ~lane_mask);
`else
  logic unused_rmw;

  assign req_rmw    = 1'b0;
  assign unused_rmw = ^{mem_rvalid, mem_rdata};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)
            state_nxt = S_DONE;
          else if (req_rmw)
            state_nxt = S_READ;
          else
            state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_gnt)
          state_nxt = S_DONE;
      end
`ifdef STORE_RMW_EN
      S_READ: begin
        if (mem_gnt)
          state_nxt = S_WAIT_R;
      end
      S_WAIT_R: begin
        if (mem_rvalid)
          state_nxt = S_WRITE;
      end
`else
      S_READ:   state_nxt = S_IDLE;
      S_WAIT_R: state_nxt = S_IDLE;
`endif
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request fields are captured once at accept so memory-side outputs stay stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= 30'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= st_addr[31:2];
        wdata_q <= req_wdata;
        be_q    <= req_be;
        err_q   <= req_err;
      end
`ifdef STORE_RMW_EN
      if (state == S_WAIT_R && mem_rvalid) begin
        wdata_q <= merged;
        be_q    <= 4'b1111;
      end
`endif
      if (state == S_DONE && !err_q)
        count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Outputs decode straight from state so an async reset drops mem_req at once
  assign st_ready  = (state == S_IDLE);
  assign st_done   = (state == S_DONE);
  assign st_err    = (state == S_DONE) && err_q;
  assign st_count  = count_q;
  assign mem_req   = (state == S_WRITE) || (state == S_READ);
  assign mem_we    = (state == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_req ? wdata_q : 32'h0;
  assign mem_be    = mem_req ? be_q : 4'h0;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: lane alignment, errors, stalls, back-to-back and reset abort.
// Exercises the read-modify-write path when STORE_RMW_EN is defined.
module tb_store_unit;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BAD = 6'b100011;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [5:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_done;
  logic        st_err;
  logic [15:0] st_count;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int assert_count;
  int fail_count;
  logic [15:0] exp_count;

  logic [5:0]  tbl_op    [5];
  logic [31:0] tbl_addr  [5];
  logic [31:0] tbl_data  [5];
  logic [3:0]  tbl_be    [5];
  logic [31:0] tbl_wdata [5];

  store_unit #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_op      (st_op),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_done    (st_done),
    .st_err     (st_err),
    .st_count   (st_count),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request and returns 1 time unit after the accepting edge
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] data, input logic gnt);
    @(negedge clk);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = addr;
    st_data  = data;
    mem_gnt  = gnt;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  task automatic test_reset;
    assert_count++; if (st_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL reset_ready: got %b expected 1", st_ready); end
    assert_count++; if (st_done !== 1'b0 || st_err !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_done: got done=%b err=%b expected 0/0", st_done, st_err); end
    assert_count++; if (st_count !== 16'h0) begin fail_count++; $display("[TB] FAIL reset_count: got %h expected 0", st_count); end
    assert_count++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== 68'h0) begin fail_count++; $display("[TB] FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h be=%b expected all 0", mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
  endtask

  task automatic test_sb;
    applyStimulus(OP_SB, 32'h0000_0013, 32'h0000_00A5, 1'b1);
    assert_count++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin fail_count++; $display("[TB] FAIL sb_req: got req=%b we=%b expected 1/1", mem_req, mem_we); end
    assert_count++; if (mem_addr !== 30'h4) begin fail_count++; $display("[TB] FAIL sb_addr: got %h expected 4", mem_addr); end
    assert_count++; if (mem_wdata !== 32'hA5A5_A5A5) begin fail_count++; $display("[TB] FAIL sb_wdata: got %h expected a5a5a5a5", mem_wdata); end
    assert_count++; if (mem_be !== 4'b1000) begin fail_count++; $display("[TB] FAIL sb_be: got %b expected 1000", mem_be); end
    assert_count++; if (st_ready !== 1'b0) begin fail_count++; $display("[TB] FAIL sb_busy: got ready=%b expected 0", st_ready); end
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    assert_count++; if (st_done !== 1'b1 || st_err !== 1'b0) begin fail_count++; $display("[TB] FAIL sb_done: got done=%b err=%b expected 1/0", st_done, st_err); end
    assert_count++; if (mem_req !== 1'b0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin fail_count++; $display("[TB] FAIL sb_mem_idle: got req=%b wdata=%h be=%b expected 0", mem_req, mem_wdata, mem_be); end
    @(posedge clk); #1;
    exp_count = exp_count + 16'd1;
    assert_count++; if (st_done !== 1'b0) begin fail_count++; $display("[TB] FAIL sb_done_pulse: got %b expected 0", st_done); end
    assert_count++; if (st_count !== exp_count) begin fail_count++; $display("[TB] FAIL sb_count: got %h expected %h", st_count, exp_count); end
    assert_count++; if (st_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL sb_ready_back: got %b expected 1", st_ready); end
  endtask

  task automatic test_sh;
    applyStimulus(OP_SH, 32'h0000_0102, 32'h1234_BEEF, 1'b1);
    assert_count++; if (mem_addr !== 30'h40) begin fail_count++; $display("[TB] FAIL sh_addr: got %h expected 40", mem_addr); end
    assert_count++; if (mem_wdata !== 32'hBEEF_BEEF) begin fail_count++; $display("[TB] FAIL sh_wdata: got %h expected beefbeef", mem_wdata); end
    assert_count++; if (mem_be !== 4'b1100 || mem_we !== 1'b1) begin fail_count++; $display("[TB] FAIL sh_be_we: got be=%b we=%b expected 1100/1", mem_be, mem_we); end
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    assert_count++; if (st_done !== 1'b1) begin fail_count++; $display("[TB] FAIL sh_done: got %b expected 1", st_done); end
    @(posedge clk); #1;
    exp_count = exp_count + 16'd1;
    assert_count++; if (st_count !== exp_count) begin fail_count++; $display("[TB] FAIL sh_count: got %h expected %h", st_count, exp_count); end
  endtask

  // Each illegal request must finish with a single done+err pulse and no memory traffic
  task automatic test_errors;
    logic [5:0]  eop   [3];
    logic [31:0] eaddr [3];
    eop[0] = OP_SW;  eaddr[0] = 32'h0000_0006;
    eop[1] = OP_SH;  eaddr[1] = 32'h0000_0101;
    eop[2] = OP_BAD; eaddr[2] = 32'h0000_0010;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(eop[i], eaddr[i], 32'hDEAD_0000 + i, 1'b0);
      assert_count++; if (st_done !== 1'b1 || st_err !== 1'b1) begin fail_count++; $display("[TB] FAIL err%0d_pulse: got done=%b err=%b expected 1/1", i, st_done, st_err); end
      assert_count++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fail_count++; $display("[TB] FAIL err%0d_noreq: got req=%b we=%b expected 0/0", i, mem_req, mem_we); end
      @(posedge clk); #1;
      assert_count++; if (st_done !== 1'b0 || st_err !== 1'b0) begin fail_count++; $display("[TB] FAIL err%0d_end: got done=%b err=%b expected 0/0", i, st_done, st_err); end
      assert_count++; if (st_count !== exp_count) begin fail_count++; $display("[TB] FAIL err%0d_count: got %h expected %h", i, st_count, exp_count); end
    end
  endtask

  task automatic test_stall;
    int done_seen;
    applyStimulus(OP_SW, 32'h0000_0008, 32'hCAFE_F00D, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      assert_count++; if (mem_req !== 1'b1 || mem_addr !== 30'h2 || mem_wdata !== 32'hCAFE_F00D || mem_be !== 4'hF) begin fail_count++; $display("[TB] FAIL stall_hold%0d: got req=%b addr=%h wdata=%h be=%b expected 1/2/cafef00d/1111", i, mem_req, mem_addr, mem_wdata, mem_be); end
      assert_count++; if (st_ready !== 1'b0 || st_done !== 1'b0) begin fail_count++; $display("[TB] FAIL stall_busy%0d: got ready=%b done=%b expected 0/0", i, st_ready, st_done); end
      if (i == 3) mem_gnt = 1'b1;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0;
    if (st_done === 1'b1) done_seen++;
    @(posedge clk); #1;
    if (st_done === 1'b1) done_seen++;
    exp_count = exp_count + 16'd1;
    assert_count++; if (done_seen != 1) begin fail_count++; $display("[TB] FAIL stall_done_count: got %0d expected 1", done_seen); end
    assert_count++; if (st_count !== exp_count) begin fail_count++; $display("[TB] FAIL stall_count: got %h expected %h", st_count, exp_count); end
  endtask

  task automatic test_lanes;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(tbl_op[i], tbl_addr[i], tbl_data[i], 1'b1);
      assert_count++; if (mem_be !== tbl_be[i] || mem_wdata !== tbl_wdata[i]) begin fail_count++; $display("[TB] FAIL lane%0d: got be=%b wdata=%h expected be=%b wdata=%h", i, mem_be, mem_wdata, tbl_be[i], tbl_wdata[i]); end
      assert_count++; if (mem_addr !== tbl_addr[i][31:2]) begin fail_count++; $display("[TB] FAIL lane%0d_addr: got %h expected %h", i, mem_addr, tbl_addr[i][31:2]); end
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(posedge clk); #1;
      exp_count = exp_count + 16'd1;
    end
    assert_count++; if (st_count !== exp_count) begin fail_count++; $display("[TB] FAIL lanes_count: got %h expected %h", st_count, exp_count); end
  endtask

  // With st_valid held high the second request must be accepted three edges after the first
  task automatic test_back_to_back;
    @(negedge clk);
    st_valid = 1'b1; st_op = OP_SB; st_addr = 32'h0000_0050; st_data = 32'h0000_0011; mem_gnt = 1'b1;
    @(posedge clk); #1;
    assert_count++; if (mem_req !== 1'b1 || mem_be !== 4'b0001) begin fail_count++; $display("[TB] FAIL b2b_first: got req=%b be=%b expected 1/0001", mem_req, mem_be); end
    @(posedge clk); #1;
    assert_count++; if (st_done !== 1'b1 || st_ready !== 1'b0) begin fail_count++; $display("[TB] FAIL b2b_done1: got done=%b ready=%b expected 1/0", st_done, st_ready); end
    st_addr = 32'h0000_0051; st_data = 32'h0000_0022;
    @(posedge clk); #1;
    assert_count++; if (st_ready !== 1'b1 || mem_req !== 1'b0) begin fail_count++; $display("[TB] FAIL b2b_idle: got ready=%b req=%b expected 1/0", st_ready, mem_req); end
    @(posedge clk); #1;
    st_valid = 1'b0;
    assert_count++; if (mem_req !== 1'b1 || mem_be !== 4'b0010 || mem_wdata !== 32'h2222_2222) begin fail_count++; $display("[TB] FAIL b2b_second: got req=%b be=%b wdata=%h expected 1/0010/22222222", mem_req, mem_be, mem_wdata); end
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(posedge clk); #1;
    exp_count = exp_count + 16'd2;
    assert_count++; if (st_count !== exp_count) begin fail_count++; $display("[TB] FAIL b2b_count: got %h expected %h", st_count, exp_count); end
  endtask

`ifdef STORE_RMW_EN
  task automatic test_rmw;
    applyStimulus(OP_SB, 32'h0000_0001, 32'h0000_0077, 1'b1);
    assert_count++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h0) begin fail_count++; $display("[TB] FAIL rmw_read: got req=%b we=%b addr=%h expected 1/0/0", mem_req, mem_we, mem_addr); end
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    assert_count++; if (mem_req !== 1'b0 || st_done !== 1'b0) begin fail_count++; $display("[TB] FAIL rmw_wait: got req=%b done=%b expected 0/0", mem_req, st_done); end
    mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    assert_count++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1122_7744 || mem_be !== 4'b1111) begin fail_count++; $display("[TB] FAIL rmw_write: got req=%b we=%b wdata=%h be=%b expected 1/1/11227744/1111", mem_req, mem_we, mem_wdata, mem_be); end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    assert_count++; if (st_done !== 1'b1 || st_err !== 1'b0) begin fail_count++; $display("[TB] FAIL rmw_done: got done=%b err=%b expected 1/0", st_done, st_err); end
    @(posedge clk); #1;
    exp_count = exp_count + 16'd1;
    assert_count++; if (st_count !== exp_count) begin fail_count++; $display("[TB] FAIL rmw_count: got %h expected %h", st_count, exp_count); end
  endtask
`endif

  task automatic test_reset_abort;
    applyStimulus(OP_SW, 32'h0000_000C, 32'h5555_AAAA, 1'b0);
    assert_count++; if (mem_req !== 1'b1) begin fail_count++; $display("[TB] FAIL abort_inwrite: got req=%b expected 1", mem_req); end
    rst_n = 1'b0;
    #1;
    assert_count++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fail_count++; $display("[TB] FAIL abort_async: got req=%b we=%b expected 0/0", mem_req, mem_we); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    assert_count++; if (st_ready !== 1'b1 || st_count !== 16'h0) begin fail_count++; $display("[TB] FAIL abort_after: got ready=%b count=%h expected 1/0", st_ready, st_count); end
    assert_count++; if (st_done !== 1'b0 || mem_req !== 1'b0) begin fail_count++; $display("[TB] FAIL abort_nodone: got done=%b req=%b expected 0/0", st_done, mem_req); end
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    exp_count    = 16'h0;
    rst_n = 1'b0; st_valid = 1'b0; st_op = 6'h0; st_addr = 32'h0; st_data = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    tbl_op[0] = OP_SB; tbl_addr[0] = 32'h0000_0020; tbl_data[0] = 32'hFFFF_FF5A; tbl_be[0] = 4'b0001; tbl_wdata[0] = 32'h5A5A_5A5A;
    tbl_op[1] = OP_SB; tbl_addr[1] = 32'h0000_0021; tbl_data[1] = 32'h0000_00C3; tbl_be[1] = 4'b0010; tbl_wdata[1] = 32'hC3C3_C3C3;
    tbl_op[2] = OP_SB; tbl_addr[2] = 32'h0000_0022; tbl_data[2] = 32'h0000_0001; tbl_be[2] = 4'b0100; tbl_wdata[2] = 32'h0101_0101;
    tbl_op[3] = OP_SH; tbl_addr[3] = 32'h0000_0030; tbl_data[3] = 32'hFFFF_1234; tbl_be[3] = 4'b0011; tbl_wdata[3] = 32'h1234_1234;
    tbl_op[4] = OP_SW; tbl_addr[4] = 32'h0000_0040; tbl_data[4] = 32'h89AB_CDEF; tbl_be[4] = 4'b1111; tbl_wdata[4] = 32'h89AB_CDEF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    test_reset;
`ifndef STORE_RMW_EN
    test_sb;
    test_sh;
`endif
    test_errors;
    test_stall;
`ifndef STORE_RMW_EN
    test_lanes;
    test_back_to_back;
`else
    test_rmw;
`endif
    test_reset_abort;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
